// File: rtl/md_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, sequencer states, default width.
package md_pkg;

    localparam int MD_DATA_W = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } md_state_e;

    function automatic logic md_is_div(md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// Pipeline <-> multiply/divide unit bus. The pipeline side is master, the unit is slave.
interface md_unit_ctrl_if #(parameter int DATA_W = md_pkg::MD_DATA_W);
    import md_pkg::*;

    logic              start;
    md_op_e            op;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              hi_we;
    logic              lo_we;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] hi;
    logic [DATA_W-1:0] lo;
    logic              stall;
    logic              done;
    logic              div_zero;

    modport master (
        output start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
        input  hi, lo, stall, done, div_zero
    );

    modport slave (
        input  start, op, rs_data, rt_data, hi_we, lo_we, wr_data,
        output hi, lo, stall, done, div_zero
    );

endinterface

// File: rtl/md_iter_datapath.sv
// One-bit-per-cycle shift-add multiplier / restoring divider on unsigned magnitudes.
// The divide path exists only when MD_DIV_EN is defined.
module md_iter_datapath #(
    parameter int DATA_W = md_pkg::MD_DATA_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                step,
`ifdef MD_DIV_EN
    input  logic                is_div,
`endif
    input  logic [DATA_W-1:0]   a_mag,
    input  logic [DATA_W-1:0]   b_mag,
    output logic [2*DATA_W-1:0] acc
);

    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W:0]     add_sum;

    // Multiply: low half holds the multiplier, consumed LSB first as the product shifts in.
    assign add_sum = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, b_q} : '0);

`ifdef MD_DIV_EN
    logic [DATA_W:0] trial;

    // Divide: trial subtract against the remainder shifted left by one; borrow means restore.
    assign trial = acc_q[2*DATA_W-1:DATA_W-1] - {1'b0, b_q};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            b_q   <= '0;
        end else if (load) begin
            acc_q <= {{DATA_W{1'b0}}, a_mag};
            b_q   <= b_mag;
        end else if (step) begin
`ifdef MD_DIV_EN
            if (is_div) begin
                if (trial[DATA_W])
                    acc_q <= {acc_q[2*DATA_W-2:0], 1'b0};
                else
                    acc_q <= {trial[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
            end else
`endif
            acc_q <= {add_sum, acc_q[DATA_W-1:1]};
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/md_unit_ctrl.sv
// MIPS HI/LO multiply/divide sequencer: FSM, iteration counter, sign fix-up, MTHI/MTLO path.
// Define MD_DIV_EN to build DIV/DIVU; otherwise divide starts complete as no-ops.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int DATA_W = MD_DATA_W
) (
    input  logic         Clk,
    input  logic         Reset_n,
    md_unit_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(DATA_W);

    md_state_e           state;
    logic [CNT_W-1:0]    cnt;
    logic                neg_lo;
    logic                neg_hi;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                done_q;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] prod;

    logic                op_div;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   a_mag;
    logic [DATA_W-1:0]   b_mag;
    logic                div_noop;
    logic                load;
    logic                step;

    assign op_div = md_is_div(bus.op);
    assign a_neg  = md_is_signed(bus.op) & bus.rs_data[DATA_W-1];
    assign b_neg  = md_is_signed(bus.op) & bus.rt_data[DATA_W-1];
    assign a_mag  = a_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
    assign b_mag  = b_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;

`ifdef MD_DIV_EN
    logic is_div;
    logic dz_q;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;

    assign div_noop = op_div && (bus.rt_data == '0);
    assign quo      = acc[DATA_W-1:0];
    assign rem      = acc[2*DATA_W-1:DATA_W];
`else
    assign div_noop = op_div;
`endif

    assign load = (state == IDLE) && bus.start && !div_noop;
    assign step = (state == CALC);
    assign prod = neg_lo ? (~acc + 1'b1) : acc;

    md_iter_datapath #(.DATA_W(DATA_W)) u_dp (
        .clk    (Clk),
        .rst_n  (Reset_n),
        .load   (load),
        .step   (step),
`ifdef MD_DIV_EN
        .is_div (is_div),
`endif
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (acc)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state  <= IDLE;
            cnt    <= '0;
            neg_lo <= 1'b0;
            neg_hi <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
`ifdef MD_DIV_EN
            is_div <= 1'b0;
            dz_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef MD_DIV_EN
            dz_q   <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    // A start always takes priority; a simultaneous MT write is dropped.
                    if (bus.start) begin
                        if (div_noop) begin
                            done_q <= 1'b1;
`ifdef MD_DIV_EN
                            dz_q   <= 1'b1;
`endif
                        end else begin
                            state  <= CALC;
                            cnt    <= CNT_W'(DATA_W - 1);
                            neg_lo <= a_neg ^ b_neg;
                            neg_hi <= op_div ? a_neg : (a_neg ^ b_neg);
`ifdef MD_DIV_EN
                            is_div <= op_div;
`endif
                        end
                    end else begin
                        if (bus.hi_we) hi_q <= bus.wr_data;
                        if (bus.lo_we) lo_q <= bus.wr_data;
                    end
                end
                CALC: begin
                    if (cnt == '0) state <= FIX;
                    else           cnt   <= cnt - 1'b1;
                end
                FIX: begin
`ifdef MD_DIV_EN
                    if (is_div) begin
                        lo_q <= neg_lo ? (~quo + 1'b1) : quo;
                        hi_q <= neg_hi ? (~rem + 1'b1) : rem;
                    end else
`endif
                    {hi_q, lo_q} <= prod;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.done  = done_q;
    assign bus.stall = (state != IDLE);
`ifdef MD_DIV_EN
    assign bus.div_zero = dz_q;
`else
    assign bus.div_zero = 1'b0;
`endif

endmodule
